// File: rtl/gpio_in_filter.sv
// GPIO pad input conditioning: two-flop synchroniser, optional per-bit debounce
// gated by a shared prescaler tick, and registered rise/fall pulses of the result.
module gpio_in_filter #(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 8,
    parameter int unsigned PW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pad_i,
    input  logic [DW-1:0] filt_en_i,
    input  logic [PW-1:0] cfg_div_i,
    input  logic [CW-1:0] cfg_thresh_i,
    output logic [DW-1:0] gpio_in_o,
    output logic [DW-1:0] rise_o,
    output logic [DW-1:0] fall_o
);

    logic [DW-1:0]         s1;
    logic [DW-1:0]         s2;
    logic [PW-1:0]         pre_cnt;
    logic [DW-1:0][CW-1:0] cnt;
    logic [DW-1:0][CW-1:0] cnt_next;
    logic [DW-1:0]         val_next;
    logic                  tick_c;

    // ">=" rather than "==" so lowering the divider never waits for a wrap
    assign tick_c = (pre_cnt >= cfg_div_i);

    // Per-bit accept decision: bypass, matched, threshold reached, or count a tick
    always_comb begin
        val_next = gpio_in_o;
        cnt_next = cnt;
        for (int i = 0; i < int'(DW); i++) begin
            if (!filt_en_i[i]) begin
                val_next[i] = s2[i];
                cnt_next[i] = '0;
            end else if (s2[i] == gpio_in_o[i]) begin
                cnt_next[i] = '0;
            end else if (tick_c) begin
                if (cnt[i] >= cfg_thresh_i) begin
                    val_next[i] = s2[i];
                    cnt_next[i] = '0;
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            pre_cnt   <= '0;
            cnt       <= '0;
            gpio_in_o <= '0;
            rise_o    <= '0;
            fall_o    <= '0;
        end else begin
            s1        <= pad_i;
            s2        <= s1;
            pre_cnt   <= tick_c ? '0 : pre_cnt + PW'(1);
            cnt       <= cnt_next;
            gpio_in_o <= val_next;
            rise_o    <= val_next & ~gpio_in_o;
            fall_o    <= ~val_next & gpio_in_o;
        end
    end

endmodule

// File: tb/tb_gpio_in_filter.sv
// Bench for gpio_in_filter: directed scenarios with literal expectations plus a
// long randomized run, all checked every cycle against a behavioural model.
module tb_gpio_in_filter;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;
    localparam int unsigned PW = 16;

    logic          clk;
    logic          rst;
    logic [DW-1:0] pad_i;
    logic [DW-1:0] filt_en_i;
    logic [PW-1:0] cfg_div_i;
    logic [CW-1:0] cfg_thresh_i;
    logic [DW-1:0] gpio_in_o;
    logic [DW-1:0] rise_o;
    logic [DW-1:0] fall_o;

    int checks   = 0;
    int failures = 0;

    gpio_in_filter #(.DW(DW), .CW(CW), .PW(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .pad_i        (pad_i),
        .filt_en_i    (filt_en_i),
        .cfg_div_i    (cfg_div_i),
        .cfg_thresh_i (cfg_thresh_i),
        .gpio_in_o    (gpio_in_o),
        .rise_o       (rise_o),
        .fall_o       (fall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: sync delay line (front = older sample), tick counter,
    // per-bit count of ticks spent disagreeing with the accepted level.
    logic [31:0] m_q[$];
    int          m_pre;
    int          m_cnt[32];
    logic [31:0] m_val;
    logic [31:0] m_rise;
    logic [31:0] m_fall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [31:0] s2v;
        logic [31:0] nv;
        bit          tick;
        if (rst) begin
            m_q    = '{32'h0, 32'h0};
            m_pre  = 0;
            m_val  = '0;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            return;
        end
        tick  = (m_pre >= int'(cfg_div_i));
        m_pre = tick ? 0 : m_pre + 1;
        s2v   = m_q[0];
        void'(m_q.pop_front());
        m_q.push_back(pad_i);
        nv = m_val;
        for (int i = 0; i < 32; i++) begin
            if (!filt_en_i[i]) begin
                nv[i]    = s2v[i];
                m_cnt[i] = 0;
            end else if (s2v[i] == m_val[i]) begin
                m_cnt[i] = 0;
            end else if (tick) begin
                if (m_cnt[i] >= int'(cfg_thresh_i)) begin
                    nv[i]    = s2v[i];
                    m_cnt[i] = 0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
        m_rise = nv & ~m_val;
        m_fall = ~nv & m_val;
        m_val  = nv;
    endtask

    // One clock: advance model with the inputs seen at the edge, then compare mid-cycle
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("gpio_in_o", gpio_in_o, m_val);
        check("rise_o", rise_o, m_rise);
        check("fall_o", fall_o, m_fall);
    endtask

    // Literal expectation applied to both the DUT and the model
    task automatic check_lit(input string name, input logic [31:0] dut_v,
                             input logic [31:0] mdl_v, input logic [31:0] exp);
        check(name, dut_v, exp);
        check({name, "_model"}, mdl_v, exp);
    endtask

    initial begin
        int n_fall;
        int first_fall;
        int r;
        logic [31:0] flips;

        rst          = 1'b1;
        pad_i        = 32'hFFFF_FFFF;
        filt_en_i    = '0;
        cfg_div_i    = '0;
        cfg_thresh_i = '0;

        // Reset hold and release
        for (int k = 0; k < 3; k++) begin
            step();
            check_lit("rst_gpio", gpio_in_o, m_val, 32'h0);
            check_lit("rst_rise", rise_o, m_rise, 32'h0);
            check_lit("rst_fall", fall_o, m_fall, 32'h0);
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_lit("rel_gpio", gpio_in_o, m_val, (k >= 2) ? 32'hFFFF_FFFF : 32'h0);
            check_lit("rel_rise", rise_o, m_rise, (k == 2) ? 32'hFFFF_FFFF : 32'h0);
        end

        // Bypass latency on bit 0
        pad_i = '0;
        for (int k = 0; k < 4; k++) step();
        pad_i[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_lit("byp_gpio0", 32'(gpio_in_o[0]), 32'(m_val[0]), 32'(k >= 2));
            check_lit("byp_rise0", 32'(rise_o[0]), 32'(m_rise[0]), 32'(k == 2));
        end

        // Debounce accept on bit 5: threshold 4, tick every cycle
        filt_en_i[5] = 1'b1;
        cfg_div_i    = 16'd0;
        cfg_thresh_i = 8'd4;
        pad_i[5]     = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check_lit("deb_gpio5", 32'(gpio_in_o[5]), 32'(m_val[5]), 32'(k >= 6));
            check_lit("deb_rise5", 32'(rise_o[5]), 32'(m_rise[5]), 32'(k == 6));
        end
        pad_i[5] = 1'b0;
        for (int k = 0; k < 8; k++) step();
        check_lit("deb_back5", 32'(gpio_in_o[5]), 32'(m_val[5]), 32'd0);

        // Glitch of 4 cycles is discarded
        pad_i[5] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k == 4) pad_i[5] = 1'b0;
            step();
            check_lit("gl_gpio5", 32'(gpio_in_o[5]), 32'(m_val[5]), 32'd0);
            check_lit("gl_edge5", 32'({rise_o[5], fall_o[5]}), 32'({m_rise[5], m_fall[5]}), 32'd0);
        end

        // Prescaler: divide by 4, threshold 1, falling edge on bit 7
        pad_i[7] = 1'b1;
        for (int k = 0; k < 4; k++) step();
        check_lit("pre_init7", 32'(gpio_in_o[7]), 32'(m_val[7]), 32'd1);
        filt_en_i[7] = 1'b1;
        cfg_div_i    = 16'd3;
        cfg_thresh_i = 8'd1;
        step();
        step();
        pad_i[7]   = 1'b0;
        n_fall     = 0;
        first_fall = -1;
        for (int k = 0; k < 16; k++) begin
            step();
            if (fall_o[7]) begin
                n_fall++;
                if (first_fall < 0) first_fall = k;
            end
        end
        check("pre_fall_count", 32'(n_fall), 32'd1);
        check("pre_fall_in_time", 32'(first_fall >= 0 && first_fall <= 10), 32'd1);
        check_lit("pre_final7", 32'(gpio_in_o[7]), 32'(m_val[7]), 32'd0);

        // Reset mid-count on bit 5
        cfg_div_i    = 16'd0;
        cfg_thresh_i = 8'd4;
        pad_i[5]     = 1'b1;
        for (int k = 0; k < 5; k++) step();
        check_lit("mid_pre5", 32'(gpio_in_o[5]), 32'(m_val[5]), 32'd0);
        rst = 1'b1;
        step();
        check_lit("mid_rst_gpio", gpio_in_o, m_val, 32'h0);
        check_lit("mid_rst_rise", rise_o, m_rise, 32'h0);
        check_lit("mid_rst_fall", fall_o, m_fall, 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            check_lit("post_rst5", 32'(gpio_in_o[5]), 32'(m_val[5]), 32'(k >= 6));
        end

        // Filter disabled mid-count: bit follows the synchroniser next edge
        pad_i[5] = 1'b0;
        for (int k = 0; k < 4; k++) step();
        check_lit("sw_hold5", 32'(gpio_in_o[5]), 32'(m_val[5]), 32'd1);
        filt_en_i[5] = 1'b0;
        step();
        check_lit("sw_follow5", 32'(gpio_in_o[5]), 32'(m_val[5]), 32'd0);
        check_lit("sw_fall5", 32'(fall_o[5]), 32'(m_fall[5]), 32'd1);

        // Randomized run with occasional config changes and resets
        filt_en_i    = 32'h0F0F_F0F0;
        cfg_div_i    = 16'd1;
        cfg_thresh_i = 8'd2;
        for (int c = 0; c < 4000; c++) begin
            r     = int'($urandom_range(0, 199));
            rst   = (r == 0);
            flips = $urandom() & $urandom() & $urandom();
            if ((c % 400) >= 200) flips = flips & $urandom();
            pad_i = pad_i ^ flips;
            if (r >= 196) filt_en_i = $urandom();
            if (r == 195) cfg_div_i = 16'($urandom_range(0, 4));
            if (r == 194) cfg_thresh_i = 8'($urandom_range(0, 5));
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_in_filter.md
Name: gpio_in_filter

Overview:
- Input conditioning stage between the GPIO pads and the GPIO core's gpio_i input.
- Per bit: two-flop synchronisation, then an optional debounce filter that accepts a new level only after it has been stable for a programmed number of prescaler ticks.
- Also emits one-cycle rise and fall pulses of the filtered value, for the core's interrupt logic or other consumers.
- Configuration arrives as static inputs driven by the register block.

Parameters:
DW  32  number of GPIO bits
CW  8   width of debounce threshold and per-bit counter
PW  16  width of prescaler divider

Ports:
clk           input   1    system clock
rst           input   1    synchronous reset, active-high
pad_i         input   DW   raw asynchronous pad inputs
filt_en_i     input   DW   per-bit filter enable (1 = debounce, 0 = synchronise only)
cfg_div_i     input   PW   prescaler terminal count; tick period = cfg_div_i+1 clk cycles
cfg_thresh_i  input   CW   debounce threshold; level accepted after cfg_thresh_i+1 ticks of mismatch
gpio_in_o     output  DW   filtered input value, connects to gpio core gpio_i
rise_o        output  DW   one-cycle pulse on each 0->1 of gpio_in_o
fall_o        output  DW   one-cycle pulse on each 1->0 of gpio_in_o

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). Reset has priority over all other updates.
- Reset values: gpio_in_o=0, rise_o=0, fall_o=0. Sync flops s1/s2, all counters and the prescaler are 0.
- Synchroniser: s1<=pad_i; s2<=s1, each cycle. No filtering in this path.
- Prescaler:
  - pre_cnt is PW bits. tick = (pre_cnt >= cfg_div_i).
  - On tick, pre_cnt<=0; otherwise pre_cnt<=pre_cnt+1.
  - cfg_div_i=0 gives a tick every cycle.
  - If cfg_div_i is lowered below pre_cnt, the next cycle ticks. No wait for wrap.
  - The prescaler runs continuously and is shared by all bits.
- Per bit i, bypass (filt_en_i[i]=0):
  - gpio_in_o[i]<=s2[i] every cycle; cnt[i]<=0.
- Per bit i, filtered (filt_en_i[i]=1):
  - If s2[i]==gpio_in_o[i]: cnt[i]<=0. A glitch shorter than the threshold is discarded.
  - Else, if tick and cnt[i]>=cfg_thresh_i: gpio_in_o[i]<=s2[i], cnt[i]<=0.
  - Else, if tick: cnt[i]<=cnt[i]+1. The counter never wraps because it is cleared at threshold.
  - Else: hold.
- Latency: with the pad changed before edge 0, the change appears in gpio_in_o after:
  - bypass: edge 2 (3 cycles);
  - filtered, cfg_div_i=0: edge 2+cfg_thresh_i;
  - filtered, general case: up to (cfg_thresh_i+1)*(cfg_div_i+1) cycles after s2 changes, plus 2.
- Minimum accepted pulse width (filtered, cfg_div_i=0) is cfg_thresh_i+1 cycles at s2. Shorter pulses produce no change in gpio_in_o.
- Edge outputs: registered, computed from the next and current value of gpio_in_o.
  - rise_o[i]<=next[i]&~gpio_in_o[i]; fall_o[i]<=~next[i]&gpio_in_o[i].
  - Each pulse is high in the same cycle gpio_in_o first shows the new value, and lasts exactly 1 cycle.
  - No pulses are generated on reset release.
- filt_en_i change mid-count:
  - 1->0: the bit follows s2 at the next edge and cnt is cleared.
  - 0->1: counting starts from 0.
- Config changes take effect on the next cycle. Changing cfg_thresh_i below a bit's current cnt accepts that bit on the next tick.
- Bits are fully independent, apart from the shared prescaler tick.

Test Plan:
- Reset check: hold rst 3 cycles with pad_i=32'hFFFF_FFFF and filt_en_i=0, then release -> gpio_in_o=0 and no rise_o/fall_o during reset; gpio_in_o=FFFF_FFFF at edge 2 after release, rise_o=FFFF_FFFF for exactly that 1 cycle.
- Bypass latency: filt_en_i=0, pad_i[0] 0->1 before edge 0 -> gpio_in_o[0]=1 and rise_o[0]=1 after edge 2; rise_o[0]=0 after edge 3.
- Debounce accept: filt_en_i[5]=1, cfg_div_i=0, cfg_thresh_i=4, pad_i[5] 0->1 held -> gpio_in_o[5] rises after edge 6, never earlier.
- Glitch reject: same config, pad_i[5] high for 4 cycles then low -> gpio_in_o[5] stays 0; no rise_o/fall_o pulses.
- Prescaler: cfg_div_i=3, cfg_thresh_i=1, filt_en_i[7]=1, pad_i[7] 1->0 held with gpio_in_o[7]=1 -> fall_o[7] pulses exactly once, within 2+8 cycles.
- Mid-op reset and mode switch:
  - rst asserted while cnt[5]=3 -> cnt and outputs cleared next cycle.
  - Separately, filt_en_i[5] 1->0 mid-count -> gpio_in_o[5] follows s2 on the next edge.
